// File: rtl/mod12_count_monitor.sv
// Receive-side checker for the mod-12 up/down count stream: direction lock, step/illegal errors, wrap statistics.
// Latency: every output is registered and reflects the sample taken on the previous rising edge.
// Backpressure: none; a sample is consumed on every cycle that valid is high.
module mod12_count_monitor #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic [3:0]        count_in,
    input  logic              load_in,
    input  logic              clr_stats,
    output logic              locked,
    output logic              dir_up,
    output logic              dir_change,
    output logic              err_illegal,
    output logic              err_jump,
    output logic [WRAP_W-1:0] up_wraps,
    output logic [WRAP_W-1:0] down_wraps,
    output logic [ERR_W-1:0]  err_count
);

    typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] up_nxt, dn_nxt;
    logic       is_up, is_dn;
    logic       dir_d, chg_d, ill_d, jmp_d;
    logic       upw_inc, dnw_inc, err_inc;

    assign up_nxt = (prev_q == 4'd11) ? 4'd0  : prev_q + 4'd1;
    assign dn_nxt = (prev_q == 4'd0)  ? 4'd11 : prev_q - 4'd1;
    assign is_up  = (count_in == up_nxt);
    assign is_dn  = (count_in == dn_nxt);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        dir_d   = dir_up;
        chg_d   = 1'b0;
        ill_d   = 1'b0;
        jmp_d   = 1'b0;
        upw_inc = 1'b0;
        dnw_inc = 1'b0;
        err_inc = 1'b0;
        if (valid) begin
            if (count_in > 4'd11) begin
                // prev is kept so the stream can resync from the last good value
                ill_d   = 1'b1;
                err_inc = 1'b1;
                state_d = UNLOCKED;
            end else if (load_in) begin
                prev_d  = count_in;
                state_d = SYNC;
            end else begin
                prev_d = count_in;
                case (state_q)
                    UNLOCKED: state_d = SYNC;
                    SYNC: begin
                        if (is_up || is_dn) begin
                            dir_d   = is_up;
                            state_d = LOCKED;
                        end else begin
                            jmp_d   = 1'b1;
                            err_inc = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (is_up || is_dn) begin
                            dir_d = is_up;
                            chg_d = (is_up != dir_up);
                        end else begin
                            jmp_d   = 1'b1;
                            err_inc = 1'b1;
                            state_d = SYNC;
                        end
                    end
                    default: state_d = UNLOCKED;
                endcase
                if (state_q != UNLOCKED) begin
                    upw_inc = is_up && (prev_q == 4'd11);
                    dnw_inc = is_dn && (prev_q == 4'd0);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= UNLOCKED;
            prev_q      <= 4'd0;
            locked      <= 1'b0;
            dir_up      <= 1'b1;
            dir_change  <= 1'b0;
            err_illegal <= 1'b0;
            err_jump    <= 1'b0;
            up_wraps    <= '0;
            down_wraps  <= '0;
            err_count   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            locked      <= (state_d == LOCKED);
            dir_up      <= dir_d;
            dir_change  <= chg_d;
            err_illegal <= ill_d;
            err_jump    <= jmp_d;
            // clear beats a same-cycle increment; counters stick at all-ones
            if (clr_stats)
                up_wraps <= '0;
            else if (upw_inc && (up_wraps != '1))
                up_wraps <= up_wraps + 1'b1;
            if (clr_stats)
                down_wraps <= '0;
            else if (dnw_inc && (down_wraps != '1))
                down_wraps <= down_wraps + 1'b1;
            if (clr_stats)
                err_count <= '0;
            else if (err_inc && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mod12_count_monitor.sv
// Bench for mod12_count_monitor: reference model feeds a scoreboard queue, plus directed checks.
module tb_mod12_count_monitor;

    localparam int WRAP_W   = 2;
    localparam int ERR_W    = 8;
    localparam int WRAP_MAX = (1 << WRAP_W) - 1;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              valid;
    logic [3:0]        count_in;
    logic              load_in;
    logic              clr_stats;
    logic              locked, dir_up, dir_change, err_illegal, err_jump;
    logic [WRAP_W-1:0] up_wraps, down_wraps;
    logic [ERR_W-1:0]  err_count;

    always #5 clock = ~clock;

    mod12_count_monitor #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .count_in    (count_in),
        .load_in     (load_in),
        .clr_stats   (clr_stats),
        .locked      (locked),
        .dir_up      (dir_up),
        .dir_change  (dir_change),
        .err_illegal (err_illegal),
        .err_jump    (err_jump),
        .up_wraps    (up_wraps),
        .down_wraps  (down_wraps),
        .err_count   (err_count)
    );

    typedef struct {
        bit locked, dir_up, dir_change, err_illegal, err_jump;
        int up_wraps, down_wraps, err_count;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // model state: 0 = unlocked, 1 = sync, 2 = locked
    int m_state, m_prev, m_uw, m_dw, m_ec;
    bit m_dir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_dir = 1'b1;
        m_uw = 0; m_dw = 0; m_ec = 0;
        sb_q.delete();
    endtask

    task automatic model_step(input bit v, input int cnt, input bit ld, input bit clr);
        exp_t e;
        bit   up, dn;
        e.dir_change = 0; e.err_illegal = 0; e.err_jump = 0;
        if (v) begin
            if (cnt > 11) begin
                e.err_illegal = 1;
                if (m_ec < ERR_MAX) m_ec++;
                m_state = 0;
            end else if (ld) begin
                m_prev  = cnt;
                m_state = 1;
            end else begin
                up = (cnt == (m_prev + 1) % 12);
                dn = (cnt == (m_prev + 11) % 12);
                if (m_state != 0 && up && cnt == 0 && m_uw < WRAP_MAX) m_uw++;
                if (m_state != 0 && dn && cnt == 11 && m_dw < WRAP_MAX) m_dw++;
                if (m_state == 0) m_state = 1;
                else if (up || dn) begin
                    if (m_state == 2 && up != m_dir) e.dir_change = 1;
                    m_dir   = up;
                    m_state = 2;
                end else begin
                    e.err_jump = 1;
                    if (m_ec < ERR_MAX) m_ec++;
                    m_state = 1;
                end
                m_prev = cnt;
            end
        end
        if (clr) begin m_uw = 0; m_dw = 0; m_ec = 0; end
        e.locked = (m_state == 2); e.dir_up = m_dir;
        e.up_wraps = m_uw; e.down_wraps = m_dw; e.err_count = m_ec;
        sb_q.push_back(e);
    endtask

    task automatic drive(input bit v, input int cnt, input bit ld, input bit clr);
        exp_t e;
        valid = v; count_in = cnt[3:0]; load_in = ld; clr_stats = clr;
        model_step(v, cnt, ld, clr);
        @(posedge clock);
        #1;
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_locked", locked, e.locked);
            chk("sb_dir_up", dir_up, e.dir_up);
            chk("sb_dir_change", dir_change, e.dir_change);
            chk("sb_err_illegal", err_illegal, e.err_illegal);
            chk("sb_err_jump", err_jump, e.err_jump);
            chk("sb_up_wraps", up_wraps, e.up_wraps);
            chk("sb_down_wraps", down_wraps, e.down_wraps);
            chk("sb_err_count", err_count, e.err_count);
        end
    endtask

    task automatic sample(input int cnt);
        drive(1'b1, cnt, 1'b0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_dir_up"}, dir_up, 1);
        chk({tag, "_pulses"}, {dir_change, err_illegal, err_jump}, 0);
        chk({tag, "_up_wraps"}, up_wraps, 0);
        chk({tag, "_down_wraps"}, down_wraps, 0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, r;
        reset = 1'b0; valid = 1'b0; count_in = 4'd0; load_in = 1'b0; clr_stats = 1'b0;
        model_reset();
        #12;
        check_reset_vals("rst");
        @(posedge clock); #1;
        reset = 1'b1;

        // lock on an up-run
        sample(3); chk("tp1_sync_locked", locked, 0);
        sample(4); chk("tp1_locked", locked, 1); chk("tp1_dir_up", dir_up, 1);
        sample(5); chk("tp1_no_pulse", {dir_change, err_illegal, err_jump}, 0);
        chk("tp1_up_wraps", up_wraps, 0);

        // up-wrap then reverse through the down-wrap
        for (int i = 6; i <= 11; i++) sample(i);
        sample(0);  chk("tp2_up_wraps", up_wraps, 1); chk("tp2_err_count", err_count, 0);
        sample(1);
        sample(0);  chk("tp2_dir_change", dir_change, 1);
        sample(11); chk("tp2_down_wraps", down_wraps, 1); chk("tp2_dir_down", dir_up, 0);
        chk("tp2_change_one_cycle", dir_change, 0);

        // jump error then resync
        for (int i = 10; i >= 5; i--) sample(i);
        sample(9);  chk("tp3_err_jump", err_jump, 1); chk("tp3_err_count", err_count, 1);
        chk("tp3_unlocked", locked, 0);
        sample(10); chk("tp3_relocked", locked, 1); chk("tp3_dir_up", dir_up, 1);

        // illegal value then down lock
        sample(13); chk("tp4_err_illegal", err_illegal, 1); chk("tp4_unlocked", locked, 0);
        chk("tp4_err_count", err_count, 2);
        sample(2);  chk("tp4_sync", locked, 0);
        sample(1);  chk("tp4_locked", locked, 1); chk("tp4_dir_down", dir_up, 0);

        // load, valid gaps, illegal-with-load
        sample(2); sample(3); sample(4);
        chk("tp5_locked_up", locked, 1);
        drive(1'b1, 9, 1'b1, 1'b0);
        chk("tp5_load_no_err", {err_jump, err_illegal}, 0); chk("tp5_load_unlocked", locked, 0);
        drive(1'b0, 15, 1'b0, 1'b0); drive(1'b0, 3, 1'b1, 1'b0);
        chk("tp5_gap_hold", locked, 0);
        sample(10); chk("tp5_relocked", locked, 1);
        drive(1'b0, 15, 1'b1, 1'b0);
        chk("tp5_gap_locked", locked, 1);
        drive(1'b1, 14, 1'b1, 1'b0);
        chk("tp5_ill_load", err_illegal, 1); chk("tp5_ill_load_unlocked", locked, 0);

        // wrap saturation and clear racing a wrap
        sample(11); sample(0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i <= 11; i++) sample(i);
            sample(0);
        end
        chk("tp6_up_sat", up_wraps, WRAP_MAX);
        for (int i = 1; i <= 11; i++) sample(i);
        drive(1'b1, 0, 1'b0, 1'b1);
        chk("tp6_clr_up", up_wraps, 0); chk("tp6_clr_err", err_count, 0);
        chk("tp6_clr_keeps_lock", locked, 1);
        for (int i = 1; i <= 11; i++) sample(i);
        sample(0);
        chk("tp6_count_after_clr", up_wraps, 1);

        // asynchronous reset while the clock is high
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        valid = 1'b0;
        @(posedge clock); #1;
        check_reset_vals("rst_held");
        reset = 1'b1;

        // randomised stream against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(19, 0);
            if (r < 12)      cnt = m_dir ? (m_prev + 1) % 12 : (m_prev + 11) % 12;
            else if (r < 15) cnt = m_dir ? (m_prev + 11) % 12 : (m_prev + 1) % 12;
            else if (r < 17) cnt = $urandom_range(15, 0);
            else             cnt = $urandom_range(11, 0);
            drive($urandom_range(9, 0) < 8, cnt, $urandom_range(29, 0) == 0,
                  $urandom_range(39, 0) == 0);
        end
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mod12_count_monitor.md
Name: mod12_count_monitor

Overview:
Receive-side checker for the 4-bit mod-12 up/down count stream produced by the team's counter block. It samples the count each valid cycle, infers the count direction, and flags illegal values and illegal jumps. It keeps saturating up-wrap, down-wrap and error statistics for the consuming logic and for debug. It sits downstream of the counter on the same clock domain.

Parameters:
WRAP_W, 8, width of the up_wraps and down_wraps statistic counters
ERR_W, 8, width of the err_count statistic counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
valid  input  1  count_in carries a sample this cycle
count_in  input  4  observed counter value; legal range is 0..11
load_in  input  1  producer performed a parallel load this cycle (qualified by valid)
clr_stats  input  1  synchronous clear of up_wraps, down_wraps and err_count
locked  output  1  direction is established and the stream is tracking
dir_up  output  1  inferred direction: 1 = up, 0 = down
dir_change  output  1  one-cycle pulse on a legal direction reversal
err_illegal  output  1  one-cycle pulse when count_in > 11
err_jump  output  1  one-cycle pulse on a non-adjacent step
up_wraps  output  WRAP_W  count of 11->0 transitions, saturating
down_wraps  output  WRAP_W  count of 0->11 transitions, saturating
err_count  output  ERR_W  count of err_illegal plus err_jump events, saturating

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-low. All state is updated on the rising clock edge.
- Reset values: state=UNLOCKED, prev=0, locked=0, dir_up=1, all pulses 0, all statistic counters 0.
- Reset may assert at any time, including mid-stream. The monitor returns to the reset values immediately.
- Gating: all outputs are registered, with one-cycle latency from the sample. When valid=0, state, prev and statistics hold, and all pulses are 0.
- Step definitions (mod 12): up-step when sample == (prev==11 ? 0 : prev+1). Down-step when sample == (prev==0 ? 11 : prev-1).
- Repeated value: a sample equal to prev is a jump error.
- Priority per valid cycle: illegal, then load, then step check.
- Illegal value (count_in > 11):
  - err_illegal=1, err_count+1.
  - prev is not updated; state goes to UNLOCKED.
  - load_in is ignored that cycle.
- Load (load_in=1, legal value):
  - prev=count_in, state goes to SYNC.
  - No jump check and no wrap count. dir_up holds.
- UNLOCKED, legal sample: prev=sample, state goes to SYNC.
- SYNC:
  - Up-step: dir_up=1, state goes to LOCKED.
  - Down-step: dir_up=0, state goes to LOCKED.
  - Otherwise: err_jump=1, err_count+1, stay in SYNC.
  - prev=sample in all cases. No dir_change pulse is issued from SYNC.
- LOCKED:
  - Step in the current direction: track normally.
  - Opposite step: dir_up toggles, dir_change=1, stay LOCKED.
  - Otherwise: err_jump=1, err_count+1, state goes to SYNC.
  - prev=sample in all cases.
- locked = (state == LOCKED), registered.
- Wraps count in SYNC and LOCKED only, never on a load or error cycle:
  - prev=11 to sample=0 as an up-step: up_wraps+1.
  - prev=0 to sample=11 as a down-step: down_wraps+1.
- Saturation: all statistic counters stop at their all-ones value.
- clr_stats: synchronous. It wins over a simultaneous increment, so the counter reads 0 on the next cycle. It does not affect state, dir_up or pulses.

Test Plan:
1. Reset release, then valid samples 3,4,5 -> locked=1 one cycle after the sample 4; dir_up=1; no pulses; up_wraps=0.
2. Up sequence 10,11,0,1 -> up_wraps=1 after the 0 sample; err_count=0. Then down sequence 1,0,11 -> dir_change pulse on the 0 sample; down_wraps=1; dir_up=0.
3. Locked at 5, then sample 9 -> err_jump pulse, err_count=1, locked=0. Then sample 10 -> locked=1, dir_up=1.
4. Sample 13 while locked -> err_illegal pulse, state UNLOCKED, prev unchanged. Then samples 2,1 -> SYNC then locked with dir_up=0.
5. Locked up at 4, then load_in=1 with value 9 -> no error, locked=0. Then sample 10 -> locked=1. Also: valid=0 gaps between samples -> no state change.
6. With WRAP_W=2, drive 5 up-wraps -> up_wraps saturates at 3. clr_stats together with a wrap -> up_wraps=0. Async reset asserted mid-stream -> all outputs at reset values without a clock edge.
